risc_toy_fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end for the RISC_TOY core family.

---
 rtl/risc_toy_fetch_queue_if.sv | 30 +++
 rtl/risc_toy_fetch_queue.sv | 90 +++++++++
 tb/tb_risc_toy_fetch_queue.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/risc_toy_fetch_queue_if.sv
// Fetch-queue bus: instruction memory port, redirect input and decode handshake.
interface risc_toy_fetch_queue_if #(
    parameter int AW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          IREQ;
    logic [AW-3:0] IADDR;
    logic [31:0]   INSTR;
    logic          REDIR;
    logic [AW-1:0] REDIR_PC;
    logic          O_VALID;
    logic          O_READY;
    logic [31:0]   O_INSTR;
    logic [AW-1:0] O_PC;
    logic [CW-1:0] OCC;

    // fetch-queue side
    modport master (
        output IREQ, IADDR, O_VALID, O_INSTR, O_PC, OCC,
        input  INSTR, REDIR, REDIR_PC, O_READY
    );

    // memory / branch unit / decode side
    modport slave (
        input  IREQ, IADDR, O_VALID, O_INSTR, O_PC, OCC,
        output INSTR, REDIR, REDIR_PC, O_READY
    );
endinterface

// File: rtl/risc_toy_fetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry response FIFO.
// Credit counts buffered entries plus the one fetch in flight, so a
// response always has room when it lands; a redirect flushes everything.
module risc_toy_fetch_queue #(
    parameter int            AW       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input logic                     CLK,
    input logic                     RST,
    risc_toy_fetch_queue_if.master  bus
);
    localparam int            CW  = $clog2(DEPTH + 1);
    localparam int            PW  = $clog2(DEPTH);
    localparam logic [AW-1:0] PC0 = {RESET_PC[AW-1:2], 2'b00};

    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] infl_pc;
    logic          inflight;

    logic [31:0]   q_instr [DEPTH];
    logic [AW-1:0] q_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] occ;

    logic [CW:0]   used;
    logic          ireq;
    logic          push;
    logic          pop;
    logic          o_valid;

    // Low address bits of the redirect target are ignored (word-aligned fetch).
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^bus.REDIR_PC[1:0];

    // Same-cycle pops do not return credit, keeping IREQ off the O_READY path.
    assign used    = {1'b0, occ} + {{CW{1'b0}}, inflight};
    assign ireq    = !RST && !bus.REDIR && (used < (CW+1)'(DEPTH));
    assign push    = inflight && !RST && !bus.REDIR;
    assign o_valid = !RST && (occ != '0);
    assign pop     = o_valid && bus.O_READY;

    assign bus.IREQ    = ireq;
    assign bus.IADDR   = RST ? PC0[AW-1:2] : fetch_pc[AW-1:2];
    assign bus.O_VALID = o_valid;
    assign bus.O_INSTR = o_valid ? q_instr[rd_ptr] : 32'h0;
    assign bus.O_PC    = o_valid ? q_pc[rd_ptr] : '0;
    assign bus.OCC     = occ;

    // Fetch PC and in-flight tag; reset beats redirect beats normal issue.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc <= PC0;
            inflight <= 1'b0;
            infl_pc  <= '0;
        end else if (bus.REDIR) begin
            fetch_pc <= {bus.REDIR_PC[AW-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= ireq;
            if (ireq) begin
                infl_pc  <= fetch_pc;
                fetch_pc <= fetch_pc + AW'(4);
            end
        end
    end

    // FIFO pointers and occupancy; redirect discards everything not popped this cycle.
    always_ff @(posedge CLK) begin
        if (RST || bus.REDIR) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      occ <= occ + CW'(1);
            else if (!push && pop) occ <= occ - CW'(1);
        end
    end

    // FIFO storage: the response is written with the PC it was fetched from.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_instr[wr_ptr] <= bus.INSTR;
            q_pc[wr_ptr]    <= infl_pc;
        end
    end
endmodule

// File: tb/tb_risc_toy_fetch_queue.sv
// Bench for risc_toy_fetch_queue: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_risc_toy_fetch_queue;
    localparam int          AW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    risc_toy_fetch_queue_if #(.AW(AW), .DEPTH(DEPTH)) bus();

    risc_toy_fetch_queue #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // reference model state
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    bit          m_infl;

    // memory model and observation
    bit          mreq;
    logic [29:0] maddr;
    int          ireq_cnt;
    logic [31:0] seen[$];

    int n_chk = 0;
    int n_err = 0;

    function automatic logic [31:0] word(input logic [29:0] a);
        return {a, 2'b01} ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, advance model at posedge, answer memory.
    task automatic step();
        bit          ev;
        bit          issue;
        logic [31:0] epc;
        logic [31:0] ein;
        @(negedge CLK);
        ev  = !RST && (mq.size() != 0);
        epc = ev ? mq[0].pc : 32'h0;
        ein = ev ? mq[0].instr : 32'h0;
        chk("ireq",    bus.IREQ, !RST && !bus.REDIR && (mq.size() + int'(m_infl) < DEPTH));
        chk("iaddr",   bus.IADDR, RST ? (RPC >> 2) : (m_pc >> 2));
        chk("o_valid", bus.O_VALID, ev);
        chk("o_pc",    bus.O_PC, epc);
        chk("o_instr", bus.O_INSTR, ein);
        chk("occ",     bus.OCC, mq.size());
        if (bus.O_VALID && bus.O_READY) seen.push_back(bus.O_PC);
        mreq  = bus.IREQ;
        maddr = bus.IADDR;
        if (mreq) ireq_cnt++;
        @(posedge CLK);
        if (RST) begin
            m_pc = RPC & ~32'h3;
            mq.delete();
            m_infl = 1'b0;
        end else if (bus.REDIR) begin
            m_pc = bus.REDIR_PC & ~32'h3;
            mq.delete();
            m_infl = 1'b0;
        end else begin
            issue = (mq.size() + int'(m_infl) < DEPTH);
            if (ev && bus.O_READY) void'(mq.pop_front());
            if (m_infl) mq.push_back('{word(m_ipc[31:2]), m_ipc});
            if (issue) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 32'd4;
            end
            m_infl = issue;
        end
        #1;
        bus.INSTR = mreq ? word(maddr) : $urandom;
    endtask

    initial begin
        RST          = 1'b1;
        bus.REDIR    = 1'b0;
        bus.REDIR_PC = '0;
        bus.O_READY  = 1'b0;
        bus.INSTR    = '0;
        m_pc         = RPC;
        m_infl       = 1'b0;
        ireq_cnt     = 0;
        @(posedge CLK);
        #1;

        // reset state, then streaming across the top of the address space
        repeat (2) step();
        chk("rst_occ", bus.OCC, 0);
        RST = 1'b0;
        bus.O_READY = 1'b1;
        seen.delete();
        repeat (12) step();
        chk("wrap_pc0", seen[0], 32'hFFFF_FFF8);
        chk("wrap_pc1", seen[1], 32'hFFFF_FFFC);
        chk("wrap_pc2", seen[2], 32'h0000_0000);
        chk("wrap_pc3", seen[3], 32'h0000_0004);

        // stall: exactly DEPTH fetches, then drain with no loss or duplicate
        bus.REDIR = 1'b1; bus.REDIR_PC = 32'h0; bus.O_READY = 1'b0;
        step();
        bus.REDIR = 1'b0;
        ireq_cnt = 0;
        repeat (8) step();
        chk("stall_ireq_cnt", ireq_cnt, 4);
        chk("stall_occ", bus.OCC, 4);
        chk("stall_ireq", bus.IREQ, 0);
        seen.delete();
        bus.O_READY = 1'b1;
        repeat (8) step();
        chk("drain_n", seen.size() >= 5, 1);
        chk("drain0", seen[0], 32'h0);
        chk("drain1", seen[1], 32'h4);
        chk("drain3", seen[3], 32'hC);
        chk("drain4", seen[4], 32'h10);

        // redirect with OCC=3 and a fetch in flight; unaligned target
        bus.REDIR = 1'b1; bus.REDIR_PC = 32'h0; bus.O_READY = 1'b0;
        step();
        bus.REDIR = 1'b0;
        repeat (4) step();
        chk("redir_pre_occ", bus.OCC, 3);
        bus.REDIR = 1'b1; bus.REDIR_PC = 32'h103;
        step();
        bus.REDIR = 1'b0;
        chk("redir_occ", bus.OCC, 0);
        chk("redir_valid", bus.O_VALID, 0);
        chk("redir_iaddr", bus.IADDR, 32'h40);
        seen.delete();
        bus.O_READY = 1'b1;
        repeat (6) step();
        chk("redir_first_pc", seen[0], 32'h100);

        // redirect coincident with the pop of PC 0x8
        bus.REDIR = 1'b1; bus.REDIR_PC = 32'h0;
        step();
        bus.REDIR = 1'b0;
        seen.delete();
        repeat (4) step();
        bus.REDIR = 1'b1; bus.REDIR_PC = 32'h200;
        step();
        bus.REDIR = 1'b0;
        repeat (5) step();
        chk("pop_redir_8", seen[2], 32'h8);
        chk("pop_redir_tgt", seen[3], 32'h200);

        // reset with full credit (OCC=3 plus fetch in flight)
        bus.REDIR = 1'b1; bus.REDIR_PC = 32'h0; bus.O_READY = 1'b0;
        step();
        bus.REDIR = 1'b0;
        repeat (4) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_mid_valid", bus.O_VALID, 0);
        chk("rst_mid_occ", bus.OCC, 0);
        chk("rst_mid_iaddr", bus.IADDR, RPC >> 2);
        seen.delete();
        bus.O_READY = 1'b1;
        repeat (6) step();
        chk("rst_mid_first", seen[0], RPC);

        // random traffic
        repeat (400) begin
            RST          = ($urandom_range(99) < 2);
            bus.REDIR    = ($urandom_range(99) < 6);
            bus.REDIR_PC = $urandom;
            bus.O_READY  = ($urandom_range(99) < 70);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
